// File: rtl/eth_tx_frame_gen.sv
// Ethernet test-frame source for the TSE MAC tx client interface: header, patterned payload, gap.
// Optional macro ETH_TX_FRAME_GEN_SEQNUM_EN puts the 32-bit frame number in payload bytes 0..3.
module eth_tx_frame_gen #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h8C1F_6469_1000,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int unsigned PAYLOAD_LEN = 46,
    parameter int unsigned GAP_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        busy,
    output logic [31:0] frame_count
);

    localparam int unsigned IDX_W    = 11;
    localparam int unsigned HDR_LEN  = 14;
    localparam int unsigned LAST_IDX = HDR_LEN + PAYLOAD_LEN - 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
`ifdef ETH_TX_FRAME_GEN_SEQNUM_EN
    localparam int unsigned SNAP_W   = 32;
`else
    localparam int unsigned SNAP_W   = 8;
`endif
    localparam logic [111:0] HEADER  = {DST_MAC, SRC_MAC, ETHERTYPE};

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_GAP} state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q;
    logic [SNAP_W-1:0]   snap_q;
    logic [31:0]         count_q;
    logic                valid_q, last_q, busy_q, last_d;
    logic [7:0]          data_q, data_d;

    // Byte at frame position idx, given the frame number captured at frame start.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [SNAP_W-1:0] snap);
        logic [7:0] k;
        k = 8'(idx - IDX_W'(HDR_LEN));
        if (idx < IDX_W'(HDR_LEN))
            return 8'(HEADER >> (8 * (13 - int'(idx))));
`ifdef ETH_TX_FRAME_GEN_SEQNUM_EN
        if (idx < IDX_W'(HDR_LEN + 4))
            return 8'(snap >> (8 * (3 - int'(k))));
        return k + snap[7:0];
`else
        return k + snap;
`endif
    endfunction

    always_comb begin
        idx_d  = idx_q + IDX_W'(1);
        data_d = frame_byte(idx_d, snap_q);
        last_d = (idx_d == IDX_W'(LAST_IDX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            snap_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_HEADER;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        data_q  <= frame_byte('0, snap_q);
                        last_q  <= 1'b0;
                        snap_q  <= SNAP_W'(count_q);
                    end
                end
                S_HEADER, S_PAYLOAD: begin
                    // Outputs only move on an accepted beat, so a stall holds them.
                    if (tx_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            count_q <= count_q + 32'd1;
                            gap_q   <= '0;
                            if (GAP_CYCLES > 0) begin
                                state_q <= S_GAP;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            idx_q  <= idx_d;
                            data_q <= data_d;
                            last_q <= last_d;
                            if (idx_d == IDX_W'(HDR_LEN))
                                state_q <= S_PAYLOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(GAP_LAST)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid    = valid_q;
    assign tx_data     = data_q;
    assign tx_last     = last_q;
    assign busy        = busy_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Bench for eth_tx_frame_gen: randomized tx_ready, frames checked against a byte-level frame model.
module tb_eth_tx_frame_gen;

    localparam int unsigned PLEN = 46;
    localparam int unsigned GAP  = 12;
    localparam int unsigned FLEN = 14 + PLEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        tx_ready = 1'b1;
    logic        tx_valid, tx_last, busy;
    logic [7:0]  tx_data;
    logic [31:0] frame_count;

    int checks = 0;
    int failures = 0;

    bit          rand_ready = 1'b0;
    int          stall_at = -1;
    int          stall_left = 0;
    logic [8:0]  rx_q[$];
    logic [8:0]  frm[$];
    int          frames_avail = 0;
    int          cur_beat = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;
    int          idle_run = 0;
    bit          seen_end = 1'b0;
    int          gap_q[$];
    int          valid_cycles = 0;
    logic [7:0]  stall_log[$];
    int          exp_fc = 0;

    always #5 clk = ~clk;

    eth_tx_frame_gen dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .busy        (busy),
        .frame_count (frame_count)
    );

    // Reference: byte i of the frame whose starting frame_count is fnum.
    function automatic logic [7:0] exp_byte(int i, int unsigned fnum);
        logic [111:0] hdr;
        int k;
        hdr = {48'hFFFF_FFFF_FFFF, 48'h8C1F_6469_1000, 16'h88B5};
        if (i < 14) return hdr[111 - 8*i -: 8];
        k = i - 14;
`ifdef ETH_TX_FRAME_GEN_SEQNUM_EN
        if (k < 4) return 8'(fnum >> (8 * (3 - k)));
`endif
        return 8'((k + fnum) % 256);
    endfunction

    // -1 if frm matches the model frame, else first bad position (FLEN for wrong length).
    function automatic int frame_diff(int unsigned fnum);
        logic [8:0] e;
        if (frm.size() != FLEN) return FLEN;
        for (int i = 0; i < FLEN; i++) begin
            e = {(i == FLEN - 1) ? 1'b1 : 1'b0, exp_byte(i, fnum)};
            if (frm[i] !== e) return i;
        end
        return -1;
    endfunction

    // Ready driver and beat/gap/stall monitor; samples on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            rx_q.delete();
            frames_avail = 0;
            cur_beat = 0;
            prev_stall = 1'b0;
            idle_run = 0;
            seen_end = 1'b0;
            tx_ready = 1'b1;
        end else begin
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                             tx_valid, tx_data, tx_last, prev_data, prev_last);
                end
            end
            if (tx_valid && stall_left > 0 && cur_beat == stall_at) begin
                tx_ready = 1'b0;
                stall_left--;
                stall_log.push_back(tx_data);
            end else begin
                tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (tx_valid) begin
                valid_cycles++;
                if (seen_end && idle_run > 0) gap_q.push_back(idle_run);
                idle_run = 0;
                seen_end = 1'b0;
            end else begin
                idle_run++;
            end
            if (tx_valid && tx_ready) begin
                rx_q.push_back({tx_last, tx_data});
                cur_beat++;
                if (tx_last) begin
                    frames_avail++;
                    cur_beat = 0;
                    seen_end = 1'b1;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    task automatic get_frame(output bit ok);
        int n = 0;
        ok = 1'b0;
        frm.delete();
        while (frames_avail == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (frames_avail == 0) return;
        frames_avail--;
        do frm.push_back(rx_q.pop_front()); while (frm[frm.size()-1][8] == 1'b0);
        ok = 1'b1;
    endtask

    task automatic wait_beat(int beat, output bit ok);
        int n = 0;
        while (!(tx_valid && cur_beat == beat) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (tx_valid && cur_beat == beat);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_valid, tx_last, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got valid/last/busy=%b expected 000", {tx_valid, tx_last, busy});
        end
        checks++;
        if (tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h expected 00", tx_data);
        end
        checks++;
        if (frame_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d expected 0", frame_count);
        end
        rst = 1'b0;
        exp_fc = 0;
    endtask

    task automatic test_basic;
        bit ok;
        int d;
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            get_frame(ok);
            d = ok ? frame_diff(exp_fc) : -2;
            checks++;
            if (d != -1) begin
                failures++;
                $display("FAIL basic_frame%0d: bad position %0d (len %0d), expected none (len %0d)", f + 1, d, frm.size(), FLEN);
            end
            exp_fc++;
            checks++;
            if (frame_count !== 32'(exp_fc)) begin
                failures++;
                $display("FAIL basic_count: got %0d expected %0d", frame_count, exp_fc);
            end
            if (f == 0) begin
                checks++;
                if (!ok || frm[14][7:0] !== 8'h00 || frm[FLEN-1] !== 9'h12D) begin
                    failures++;
                    $display("FAIL basic_payload_ends: got first=%h last=%h expected 00 and last-flagged 2D",
                             ok ? frm[14][7:0] : 8'hxx, ok ? frm[FLEN-1] : 9'hxxx);
                end
                checks++;
                if ({tx_valid, busy} !== 2'b01) begin
                    failures++;
                    $display("FAIL basic_gap_state: got valid/busy=%b expected 01", {tx_valid, busy});
                end
            end
`ifndef ETH_TX_FRAME_GEN_SEQNUM_EN
            if (f == 1) begin
                checks++;
                if (!ok || frm[14][7:0] !== 8'h01) begin
                    failures++;
                    $display("FAIL basic_frame2_first: got %h expected 01", ok ? frm[14][7:0] : 8'hxx);
                end
            end
`endif
        end
    endtask

    task automatic test_stall;
        bit ok;
        int d;
        stall_log.delete();
        stall_at = 7;
        stall_left = 5;
        for (int f = 0; f < 3; f++) begin
            get_frame(ok);
            d = ok ? frame_diff(exp_fc) : -2;
            checks++;
            if (d != -1) begin
                failures++;
                $display("FAIL stall_frame: bad position %0d expected none", d);
            end
            exp_fc++;
            if (stall_left == 0 && stall_log.size() == 5) break;
        end
        checks++;
        if (stall_log.size() != 5) begin
            failures++;
            $display("FAIL stall_cycles: got %0d stalled valid cycles expected 5", stall_log.size());
        end
        foreach (stall_log[i]) begin
            checks++;
            if (stall_log[i] !== 8'h1F) begin
                failures++;
                $display("FAIL stall_data: got %h expected 1F", stall_log[i]);
            end
        end
        stall_at = -1;
    endtask

    task automatic test_random_ready;
        bit ok;
        int d;
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            get_frame(ok);
            d = ok ? frame_diff(exp_fc) : -2;
            checks++;
            if (d != -1) begin
                failures++;
                $display("FAIL random_frame: frame %0d bad position %0d expected none", exp_fc, d);
            end
            exp_fc++;
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int bad = 0;
        logic [7:0] f257 = 8'hxx;
        gap_q.delete();
        while (exp_fc < 257) begin
            get_frame(ok);
            if (!ok) break;
            if (frame_diff(exp_fc) != -1) bad++;
            if (exp_fc == 256) f257 = frm[14][7:0];
            exp_fc++;
        end
        checks++;
        if (bad != 0 || exp_fc != 257) begin
            failures++;
            $display("FAIL b2b_frames: got %0d bad, reached %0d, expected 0 bad, 257", bad, exp_fc);
        end
        checks++;
        if (f257 !== 8'h00) begin
            failures++;
            $display("FAIL b2b_frame257_first: got %h expected 00", f257);
        end
        checks++;
        if (gap_q.size() < 100) begin
            failures++;
            $display("FAIL b2b_gap_count: got %0d gaps expected at least 100", gap_q.size());
        end
        foreach (gap_q[i]) begin
            if (gap_q[i] != GAP + 1) begin
                checks++;
                failures++;
                $display("FAIL b2b_gap: got %0d idle clocks expected %0d", gap_q[i], GAP + 1);
                break;
            end
        end
        checks++;
        if (frame_count !== 32'(exp_fc)) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_enable_drop;
        bit ok;
        int d, vc;
        wait_beat(14 + 20, ok);
        enable = 1'b0;
        get_frame(ok);
        d = ok ? frame_diff(exp_fc) : -2;
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL drop_frame: bad position %0d expected none", d);
        end
        exp_fc++;
        checks++;
        if (frame_count !== 32'(exp_fc)) begin
            failures++;
            $display("FAIL drop_count: got %0d expected %0d", frame_count, exp_fc);
        end
        vc = valid_cycles;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (valid_cycles != vc || busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_quiet: got %0d extra valid cycles busy=%b expected 0 and 0", valid_cycles - vc, busy);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d;
        enable = 1'b1;
        wait_beat(14 + 30, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_reach: got no payload byte 30 expected one");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tx_valid, tx_last, busy} !== 3'b000 || tx_data !== 8'h00 || frame_count !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got v/l/b=%b data=%h count=%0d expected 000 00 0",
                     {tx_valid, tx_last, busy}, tx_data, frame_count);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_fc = 0;
        get_frame(ok);
        checks++;
        if (!ok || frm[0][7:0] !== 8'hFF) begin
            failures++;
            $display("FAIL rstmid_first: got %h expected FF", ok ? frm[0][7:0] : 8'hxx);
        end
        d = ok ? frame_diff(exp_fc) : -2;
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL rstmid_frame: bad position %0d expected none", d);
        end
        exp_fc++;
    endtask

    task automatic test_seqnum;
        bit ok;
        int d;
        logic [7:0] exp5 [5];
`ifdef ETH_TX_FRAME_GEN_SEQNUM_EN
        exp5 = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h07};
`else
        exp5 = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_fc = 0;
        enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            get_frame(ok);
            d = ok ? frame_diff(exp_fc) : -2;
            checks++;
            if (d != -1) begin
                failures++;
                $display("FAIL seq_frame%0d: bad position %0d expected none", f + 1, d);
            end
            exp_fc++;
        end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (!ok || frm[14 + k][7:0] !== exp5[k]) begin
                failures++;
                $display("FAIL seq_byte%0d: got %h expected %h", k, ok ? frm[14 + k][7:0] : 8'hxx, exp5[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random_ready();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_seqnum();
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
